// File: rtl/ifu_fetch.sv
// ifu_fetch: instruction fetch unit with a PC, one outstanding memory request and a 1-entry stall buffer.
// Define IFU_PERF_CNT_EN to add the perf_fetch_o / perf_stall_o counters.
`ifndef INST_NOP
`define INST_NOP 32'h0000_0013
`endif

module ifu_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        jump_en_i,
    input  logic [31:0] jump_addr_i,
    input  logic        hold_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic [31:0] inst_o,
    output logic [31:0] inst_addr_o,
    output logic        inst_valid_o
`ifdef IFU_PERF_CNT_EN
    ,
    output logic [31:0] perf_fetch_o,
    output logic [31:0] perf_stall_o
`endif
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

    state_t      state_reg, state_next;
    logic [31:0] pc_reg;
    logic [31:0] addr_q_reg;
    logic        kill_reg;
    logic        buf_valid_reg;
    logic [31:0] buf_inst_reg;
    logic [31:0] buf_addr_reg;
    logic [31:0] inst_reg;
    logic [31:0] inst_addr_reg;
    logic        inst_valid_reg;

    logic        req_fire;
    logic        resp;
    logic        resp_live;

    assign req_fire  = imem_req_o & imem_gnt_i;
    assign resp      = (state_reg == S_WAIT) & imem_rvalid_i;
    // A response is usable only if it was not killed by an earlier jump or by a jump right now.
    assign resp_live = resp & ~kill_reg & ~jump_en_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // A jump never changes the state: a request granted in the jump cycle still has to be drained.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:  state_next = S_REQ;
            S_REQ:   if (req_fire) state_next = S_WAIT;
            S_WAIT:  if (imem_rvalid_i) state_next = S_REQ;
            default: state_next = S_IDLE;
        endcase
    end

    // Issue is blocked while stalled and while the buffer still holds an undelivered word.
    always_comb begin
        imem_req_o  = (state_reg == S_REQ) && !hold_i && !buf_valid_reg;
        imem_addr_o = pc_reg;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_reg         <= RESET_PC & ~32'h3;
            addr_q_reg     <= 32'h0;
            kill_reg       <= 1'b0;
            buf_valid_reg  <= 1'b0;
            buf_inst_reg   <= `INST_NOP;
            buf_addr_reg   <= 32'h0;
            inst_reg       <= `INST_NOP;
            inst_addr_reg  <= 32'h0;
            inst_valid_reg <= 1'b0;
        end else begin
            if (jump_en_i) begin
                pc_reg <= jump_addr_i & ~32'h3;
            end else if (req_fire) begin
                pc_reg <= pc_reg + 32'd4;
            end

            if (req_fire) begin
                addr_q_reg <= pc_reg;
            end

            if (jump_en_i) begin
                kill_reg <= ((state_reg == S_WAIT) && !imem_rvalid_i) || req_fire;
            end else if (resp) begin
                kill_reg <= 1'b0;
            end

            if (jump_en_i) begin
                buf_valid_reg  <= 1'b0;
                inst_reg       <= `INST_NOP;
                inst_addr_reg  <= 32'h0;
                inst_valid_reg <= 1'b0;
            end else if (hold_i) begin
                if (resp_live) begin
                    buf_valid_reg <= 1'b1;
                    buf_inst_reg  <= imem_rdata_i;
                    buf_addr_reg  <= addr_q_reg;
                end
            end else if (buf_valid_reg) begin
                buf_valid_reg  <= 1'b0;
                inst_reg       <= buf_inst_reg;
                inst_addr_reg  <= buf_addr_reg;
                inst_valid_reg <= 1'b1;
            end else if (resp_live) begin
                inst_reg       <= imem_rdata_i;
                inst_addr_reg  <= addr_q_reg;
                inst_valid_reg <= 1'b1;
            end else begin
                inst_reg       <= `INST_NOP;
                inst_valid_reg <= 1'b0;
            end
        end
    end

    assign inst_o       = inst_reg;
    assign inst_addr_o  = inst_addr_reg;
    assign inst_valid_o = inst_valid_reg;

`ifdef IFU_PERF_CNT_EN
    logic [31:0] perf_fetch_reg;
    logic [31:0] perf_stall_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetch_reg <= 32'h0;
            perf_stall_reg <= 32'h0;
        end else begin
            if (resp_live) perf_fetch_reg <= perf_fetch_reg + 32'd1;
            if (hold_i)    perf_stall_reg <= perf_stall_reg + 32'd1;
        end
    end

    assign perf_fetch_o = perf_fetch_reg;
    assign perf_stall_o = perf_stall_reg;
`endif

endmodule

// File: tb/tb_ifu_fetch.sv
// Randomized scoreboard bench for ifu_fetch: a transaction-level fetch model predicts requests and
// delivered instructions; a separate monitor compares IF/ID outputs after every clock edge.
module tb_ifu_fetch;

    localparam logic [31:0] RST_PC = 32'h8000_0000;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        jump_en = 1'b0;
    logic [31:0] jump_addr = 32'h0;
    logic        hold = 1'b0;
    logic        req;
    logic [31:0] imem_addr;
    logic        gnt = 1'b0;
    logic        rvalid = 1'b0;
    logic [31:0] rdata = 32'h0;
    logic [31:0] inst;
    logic [31:0] inst_addr;
    logic        inst_valid;
`ifdef IFU_PERF_CNT_EN
    logic [31:0] perf_fetch;
    logic [31:0] perf_stall;
`endif

    ifu_fetch #(.RESET_PC(RST_PC)) dut (
        .clk          (clk),
        .rst          (rst),
        .jump_en_i    (jump_en),
        .jump_addr_i  (jump_addr),
        .hold_i       (hold),
        .imem_req_o   (req),
        .imem_addr_o  (imem_addr),
        .imem_gnt_i   (gnt),
        .imem_rvalid_i(rvalid),
        .imem_rdata_i (rdata),
        .inst_o       (inst),
        .inst_addr_o  (inst_addr),
        .inst_valid_o (inst_valid)
`ifdef IFU_PERF_CNT_EN
        ,
        .perf_fetch_o (perf_fetch),
        .perf_stall_o (perf_stall)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] addr;
    } fetch_t;

    typedef struct packed {
        logic r;
        logic h;
        logic j;
    } edge_t;

    fetch_t exp_q[$];
    edge_t  edge_q[$];

    int checks = 0;
    int errors = 0;
    int n_deliv = 0;

    // Fetch-level model state
    logic [31:0] model_pc = RST_PC;
    bit          in_idle = 1'b1;
    bit          outstanding = 1'b0;
    bit          out_killed = 1'b0;
    logic [31:0] out_addr = 32'h0;
    int          lat = 0;
    int          lat_max = 0;
    bit          stale_pending = 1'b0;
    logic [31:0] m_fetch = 32'h0;
    logic [31:0] m_stall = 32'h0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[7:0], a[31:8]} ^ 32'hC3A5_0F1E;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Drives one cycle of inputs, checks the request interface, and advances the model by one edge.
    task automatic cycle(input bit r, input bit h, input bit j, input logic [31:0] ja, input bit g);
        bit do_rv;
        bit exp_req;
        bit grant;
        bit pushed;
        @(negedge clk);
        rst = r; hold = h; jump_en = j; jump_addr = ja; gnt = g;
        do_rv = 1'b0;
        if (!r) begin
            if (stale_pending) begin
                do_rv = 1'b1;
                stale_pending = 1'b0;
            end else if (outstanding) begin
                if (lat == 0) do_rv = 1'b1;
                else lat--;
            end
        end
        rvalid = do_rv;
        rdata  = (do_rv && outstanding) ? mem_word(out_addr) : $urandom;
        #1;
        exp_req = !in_idle && !outstanding && (exp_q.size() == 0) && !h;
        chk("imem_req", {31'b0, req}, {31'b0, exp_req});
        if (req && exp_req) chk("imem_addr", imem_addr, model_pc);
        if (r) begin
            if (outstanding) stale_pending = 1'b1;
            outstanding = 1'b0;
            out_killed  = 1'b0;
            exp_q.delete();
            model_pc = RST_PC;
            in_idle  = 1'b1;
            m_fetch  = 32'h0;
            m_stall  = 32'h0;
        end else begin
            grant  = exp_req && g;
            pushed = 1'b0;
            if (do_rv && outstanding) begin
                outstanding = 1'b0;
                if (!out_killed && !j) begin
                    exp_q.push_back('{inst: mem_word(out_addr), addr: out_addr});
                    pushed = 1'b1;
                end
            end
            if (grant) begin
                outstanding = 1'b1;
                out_addr    = model_pc;
                out_killed  = j;
                lat         = $urandom_range(0, lat_max);
            end else if (j && outstanding) begin
                out_killed = 1'b1;
            end
            if (j) begin
                model_pc = ja & ~32'h3;
                exp_q.delete();
            end else if (grant) begin
                model_pc = model_pc + 32'd4;
            end
            in_idle = 1'b0;
            if (pushed) m_fetch = m_fetch + 32'd1;
            if (h) m_stall = m_stall + 32'd1;
        end
        edge_q.push_back('{r: r, h: h, j: j});
    endtask

    // Monitor: judges the IF/ID outputs produced by each edge.
    initial begin : monitor
        edge_t       rec;
        fetch_t      e;
        logic [31:0] prev_inst;
        logic [31:0] prev_addr;
        logic        prev_valid;
        prev_inst = NOP; prev_addr = 32'h0; prev_valid = 1'b0;
        forever begin
            @(posedge clk);
            #3;
            if (edge_q.size() != 0) begin
                rec = edge_q.pop_front();
                if (rec.r || rec.j) begin
                    chk(rec.r ? "rst_valid" : "jump_valid", {31'b0, inst_valid}, 32'h0);
                    chk(rec.r ? "rst_inst" : "jump_inst", inst, NOP);
                    chk(rec.r ? "rst_addr" : "jump_addr", inst_addr, 32'h0);
                end else if (rec.h) begin
                    chk("hold_valid", {31'b0, inst_valid}, {31'b0, prev_valid});
                    chk("hold_inst", inst, prev_inst);
                    chk("hold_addr", inst_addr, prev_addr);
                end else if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("deliver_valid", {31'b0, inst_valid}, 32'h1);
                    chk("deliver_inst", inst, e.inst);
                    chk("deliver_addr", inst_addr, e.addr);
                    n_deliv++;
                    $display("deliver addr=%h inst=%h t=%0t", inst_addr, inst, $time);
                end else begin
                    chk("bubble_valid", {31'b0, inst_valid}, 32'h0);
                    chk("bubble_inst", inst, NOP);
                end
            end
            prev_inst = inst; prev_addr = inst_addr; prev_valid = inst_valid;
        end
    end

    task automatic random_phase(input int n, input int hold_pct, input int jump_pct, input int gnt_pct);
        bit          h;
        bit          j;
        bit          g;
        logic [31:0] ja;
        for (int i = 0; i < n; i++) begin
            h  = ($urandom_range(0, 99) < hold_pct);
            j  = ($urandom_range(0, 99) < jump_pct);
            g  = ($urandom_range(0, 99) < gnt_pct);
            ja = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF4 + {28'b0, 4'($urandom_range(0, 11))}
                                             : $urandom;
            cycle(1'b0, h, j, ja, g);
        end
    endtask

    initial begin : stimulus
        cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
`ifdef IFU_PERF_CNT_EN
        chk("perf_fetch_rst", perf_fetch, 32'h0);
        chk("perf_stall_rst", perf_stall, 32'h0);
`endif
        // Immediate grant and next-cycle data: straight-line stream from the reset PC.
        lat_max = 0;
        random_phase(24, 0, 0, 100);
        // Stalls only, then stalls plus redirects, with variable memory latency.
        lat_max = 3;
        random_phase(300, 30, 0, 70);
        random_phase(1500, 25, 7, 70);
        // Reset while a request is outstanding; its late response must be ignored.
        for (int k = 0; k < 4; k++) begin
            for (int w = 0; w < 20 && !outstanding; w++) cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
            lat = 5;
            cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
            cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
            random_phase(60, 20, 5, 80);
        end
        random_phase(40, 0, 0, 100);
        @(posedge clk);
        #4;
`ifdef IFU_PERF_CNT_EN
        chk("perf_fetch", perf_fetch, m_fetch);
        chk("perf_stall", perf_stall, m_stall);
`endif
        chk("progress", {31'b0, (n_deliv > 200)}, 32'h1);
        chk("edge_queue_drained", edge_q.size(), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
